mxint8_broadcast_seq: RTL and testbench
=======================================

Name: mxint8_broadcast_seq

Overview:
- Stream sequencer around the combinational mxint8_broadcast unit.
- Accepts float32 scalars on a valid/ready input and registers each one.
- Drives the registered scalar into an internal mxint8_broadcast instance.
- Serialises the result onto a byte-wide valid/ready output as one MX block: one scale beat, then BLOCK_SIZE element beats, repeated a programmable number of times.
- Sits between the scalar operand path and the MX block buffers/ALU.

Parameters:
- BLOCK_SIZE, 32, elements per MX block; must match the broadcast unit.
- ELEM_WIDTH, 8, MXINT8 element width in bits.
- SCALE_WIDTH, 8, shared-scale width in bits.
- IDX_WIDTH, 5, element index width; equals clog2(BLOCK_SIZE).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  input scalar valid.
- o_ready  out  1  input scalar ready.
- i_float32  in  32  IEEE-754 single-precision scalar.
- i_repeat  in  8  blocks to emit for this scalar; 0 is treated as 1.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream ready.
- o_data  out  8  scale byte or MXINT8 element byte.
- o_is_scale  out  1  current beat is a scale beat.
- o_elem_last  out  1  current beat is the last element of a block.
- o_burst_last  out  1  current beat is the last beat of the final block for this scalar.
- o_nan  out  1  latched scale equals 0xFF; valid only while o_valid is high.

Behaviour:
- Reset, sampled on the clock edge while i_rst=1:
  - state=IDLE; idx=0; blocks_left=0; latched scalar=0.
  - While i_rst is high: o_ready=0, o_valid=0, o_is_scale=0, o_elem_last=0, o_burst_last=0, o_nan=0, o_data=0.
  - Reset mid-burst abandons the burst; no further beats are emitted.
- Handshakes: input transfers when i_valid & o_ready; output transfers when o_valid & i_ready.
- While o_valid=1 & i_ready=0: o_data and all flags hold stable.
- FSM states:
  - IDLE:
    - o_ready=1, o_valid=0.
    - On input transfer: latch i_float32; blocks_left = max(i_repeat,1); go to SCALE.
  - SCALE:
    - o_valid=1, o_is_scale=1, o_data=broadcast scale.
    - On output transfer: idx=0; go to ELEM.
  - ELEM:
    - o_valid=1, o_data=element[idx].
    - o_elem_last = (idx==BLOCK_SIZE-1).
    - On output transfer with idx<BLOCK_SIZE-1: idx+1.
    - On output transfer with idx==BLOCK_SIZE-1 and blocks_left>1: decrement blocks_left; go to SCALE.
    - On output transfer with idx==BLOCK_SIZE-1 and blocks_left==1: go to IDLE.
- o_burst_last = ELEM & idx==BLOCK_SIZE-1 & blocks_left==1.
- o_ready is low in SCALE and ELEM; one scalar is in flight at a time.
- Latency: input transfer at cycle T gives the first scale beat valid at T+1.
- With i_ready held high, a burst takes 1+(BLOCK_SIZE+1)*repeat cycles including the IDLE accept cycle.
- Conversion (from mxint8_broadcast, fed by the latched register, never by the live i_float32):
  - Round to nearest even to 6 fraction bits.
  - Rounding carry increments the scale.
  - Scale 0xFE with carry clamps to scale 0xFE and maximum magnitude.
  - Exponent 0xFF passes through as scale 0xFF (NaN); element bytes are don't-care when o_nan=1.
  - Element = two's complement of {1,frac6}, so 1.0 → 0x40.
- Subnormal inputs are not supported; their output is undefined, and the bench does not check it.
- Changes to i_float32/i_repeat while o_ready=0 have no effect.

Test Plan:
- 0x3F800000 (1.0), repeat=1, i_ready=1 → 33 beats: 0x7F with o_is_scale=1, then 32×0x40. Beat 33 has o_elem_last=o_burst_last=1. o_ready returns high the next cycle.
- 0xBFC00000 (-1.5), repeat=3, i_ready=1 → 99 beats; scale 0x7F at beats 1, 34 and 67; all elements 0xA0; o_burst_last only on beat 99.
- 0x3FFFFFFF, repeat=0 → repeat treated as 1: scale 0x80 followed by 32×0x40. Also 0x7F7FFFFF → scale 0xFE, elements 0x7F.
- 0x7FC00000 → first beat scale 0xFF with o_nan=1; 32 element beats still emitted (values unchecked); o_burst_last on beat 33.
- Random i_ready backpressure with i_valid held high and new i_float32 values presented → o_data/flags stable while stalled; exact 33-beat sequence per scalar; input accepted only in IDLE.
- i_rst pulsed for 1 cycle at element beat 10 → next cycle o_valid=0, o_ready=1; a new scalar 0x40000000 yields scale 0x80 then 32×0x40.

Source files
------------

// File: rtl/mxint8_broadcast_seq.sv
// mxint8_broadcast_seq: registers float32 scalars and streams each as repeated MXINT8 blocks
// (one scale byte, then BLOCK_SIZE element bytes) over a byte-wide valid/ready port.
module mxint8_broadcast #(
   parameter int BLOCK_SIZE  = 32,
   parameter int ELEM_WIDTH  = 8,
   parameter int SCALE_WIDTH = 8
) (
   input  logic [31:0]            float32_i,
   output logic [SCALE_WIDTH-1:0] scale_o,
   output logic [ELEM_WIDTH-1:0]  elems_o [BLOCK_SIZE]
);
   localparam int FW = ELEM_WIDTH - 2;
   logic [7:0]          exp_w;
   logic [22:0]         frac_w;
   logic                rnd_w;
   logic [FW+1:0]       mant_w;
   logic                carry_w;
   logic [FW:0]         mag_w;
   logic [ELEM_WIDTH-1:0] elem_w;
   assign exp_w   = float32_i[30:23];
   assign frac_w  = float32_i[22:0];
   // round to nearest even on the bits dropped below FW fraction bits
   assign rnd_w   = frac_w[22-FW] & ((|frac_w[21-FW:0]) | frac_w[23-FW]);
   assign mant_w  = {2'b01, frac_w[22 -: FW]} + {{(FW+1){1'b0}}, rnd_w};
   assign carry_w = mant_w[FW+1];
   assign mag_w   = !carry_w ? mant_w[FW:0] : exp_w == 8'hFE ? {(FW+1){1'b1}} : {1'b1, {FW{1'b0}}};
   assign elem_w  = float32_i[31] ? -{1'b0, mag_w} : {1'b0, mag_w};
   assign scale_o = exp_w == 8'hFF ? 8'hFF : (carry_w && exp_w != 8'hFE) ? exp_w + 8'd1 : exp_w;
   for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_bc
      assign elems_o[g] = elem_w;
   end
endmodule

module mxint8_broadcast_seq #(
   parameter int BLOCK_SIZE  = 32,
   parameter int ELEM_WIDTH  = 8,
   parameter int SCALE_WIDTH = 8,
   parameter int IDX_WIDTH   = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [31:0]           i_float32,
   input  logic [7:0]            i_repeat,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [ELEM_WIDTH-1:0] o_data,
   output logic                  o_is_scale,
   output logic                  o_elem_last,
   output logic                  o_burst_last,
   output logic                  o_nan
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCALE = 2'd1;
   localparam logic [1:0] ELEM  = 2'd2;
   logic [1:0]           state_q, state_d;
   logic [IDX_WIDTH-1:0] idx_q, idx_d;
   logic [7:0]           blocks_q, blocks_d;
   logic [31:0]          f32_q, f32_d;
   logic [SCALE_WIDTH-1:0] scale_w;
   logic [ELEM_WIDTH-1:0]  elems_w [BLOCK_SIZE];
   logic                 in_xfer, out_xfer, last_idx;
   mxint8_broadcast #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .ELEM_WIDTH (ELEM_WIDTH),
      .SCALE_WIDTH(SCALE_WIDTH)
   ) u_bc (
      .float32_i(f32_q),
      .scale_o  (scale_w),
      .elems_o  (elems_w)
   );
   assign o_ready      = !i_rst && state_q == IDLE;
   assign o_valid      = !i_rst && state_q != IDLE;
   assign o_is_scale   = !i_rst && state_q == SCALE;
   assign last_idx     = idx_q == IDX_WIDTH'(BLOCK_SIZE - 1);
   assign o_elem_last  = !i_rst && state_q == ELEM && last_idx;
   assign o_burst_last = o_elem_last && blocks_q == 8'd1;
   assign o_nan        = o_valid && scale_w == 8'hFF;
   assign o_data       = !o_valid ? '0 : o_is_scale ? scale_w : elems_w[idx_q];
   assign in_xfer      = i_valid && o_ready;
   assign out_xfer     = o_valid && i_ready;
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      blocks_d = blocks_q;
      f32_d    = f32_q;
      if (in_xfer) begin
         f32_d    = i_float32;
         blocks_d = i_repeat == 8'd0 ? 8'd1 : i_repeat;
         state_d  = SCALE;
      end
      if (out_xfer && state_q == SCALE) begin
         idx_d   = '0;
         state_d = ELEM;
      end
      if (out_xfer && state_q == ELEM) begin
         idx_d    = last_idx ? idx_q : idx_q + 1'b1;
         blocks_d = last_idx && blocks_q > 8'd1 ? blocks_q - 8'd1 : blocks_q;
         state_d  = !last_idx ? ELEM : blocks_q > 8'd1 ? SCALE : IDLE;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         blocks_q <= '0;
         f32_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         blocks_q <= blocks_d;
         f32_q    <= f32_d;
      end
   end
endmodule

// File: tb/tb_mxint8_broadcast_seq.sv
// tb_mxint8_broadcast_seq: scoreboard bench; driver pushes expected beats from an arithmetic
// model, a negedge monitor pops and compares every accepted output beat.
module tb_mxint8_broadcast_seq;
   logic        clk = 0;
   logic        rst = 1;
   logic        i_valid = 0;
   logic        o_ready;
   logic [31:0] i_float32 = 0;
   logic [7:0]  i_repeat = 0;
   logic        o_valid;
   logic        i_ready = 1;
   logic [7:0]  o_data;
   logic        o_is_scale, o_elem_last, o_burst_last, o_nan;

   typedef struct {
      logic [7:0] d;
      logic       s, el, bl, n, chkd;
   } beat_t;
   beat_t sb[$];
   int    n_checks = 0;
   int    n_fail = 0;
   logic  rand_ready = 0;
   logic  hold_valid = 0;

   mxint8_broadcast_seq dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_float32   (i_float32),
      .i_repeat    (i_repeat),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_is_scale  (o_is_scale),
      .o_elem_last (o_elem_last),
      .o_burst_last(o_burst_last),
      .o_nan       (o_nan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // value/2^23 scaled to 6 fraction bits with round-half-even, then clamp/carry rules
   function automatic void model(input logic [31:0] f, output logic [7:0] sc, output logic [7:0] el);
      int e = int'(f[30:23]);
      int m = int'({1'b1, f[22:0]});
      int q = m / 131072;
      int r = m % 131072;
      if (r > 65536 || (r == 65536 && q % 2 == 1)) q++;
      if (q == 128) begin
         if (e == 254) q = 127;
         else begin
            q = 64;
            e++;
         end
      end
      if (f[30:23] == 8'hFF) e = 255;
      sc = 8'(e);
      el = f[31] ? 8'(-q) : 8'(q);
   endfunction

   task automatic push_expected(input logic [31:0] f, input logic [7:0] rep);
      logic [7:0] sc, el;
      int nb;
      beat_t b;
      model(f, sc, el);
      nb = rep == 0 ? 1 : int'(rep);
      for (int k = 0; k < nb; k++) begin
         b = '{d: sc, s: 1, el: 0, bl: 0, n: sc == 8'hFF, chkd: 1};
         sb.push_back(b);
         for (int i = 0; i < 32; i++) begin
            b = '{d: el, s: 0, el: i == 31, bl: i == 31 && k == nb - 1, n: sc == 8'hFF, chkd: sc != 8'hFF};
            sb.push_back(b);
         end
      end
   endtask

   function automatic logic [31:0] rnd_f32();
      return {1'($urandom), 8'($urandom_range(1, 255)), 23'($urandom)};
   endfunction

   // offers a scalar until accepted; with hold_valid, stalled cycles present fresh junk scalars
   task automatic send(input logic [31:0] f, input logic [7:0] rep);
      int t = 0;
      @(posedge clk); #1;
      i_valid = 1; i_float32 = f; i_repeat = rep;
      forever begin
         @(negedge clk);
         if (o_ready) break;
         if (++t > 2000) begin
            chk("accept_timeout", 0, 1);
            return;
         end
         if (hold_valid) begin
            @(posedge clk); #1;
            i_float32 = rnd_f32(); i_repeat = 8'($urandom_range(0, 2));
         end
      end
      push_expected(i_float32, i_repeat);
      @(posedge clk); #1;
      if (!hold_valid) i_valid = 0;
      else begin
         i_float32 = rnd_f32(); i_repeat = 8'($urandom_range(0, 2));
      end
      @(negedge clk);
      chk("first_beat_latency", {o_valid, o_is_scale, o_ready}, 3'b110);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_done", sb.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      i_ready = rand_ready ? 1'($urandom) : 1'b1;
   end

   initial begin : monitor
      logic        held = 0;
      logic [12:0] held_vec = '0;
      beat_t       b;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("reset_outputs", {o_ready, o_valid, o_data, o_is_scale, o_elem_last, o_burst_last, o_nan}, 0);
            held = 0;
         end else begin
            if (held) chk("stall_stable", {o_valid, o_data, o_is_scale, o_elem_last, o_burst_last, o_nan}, held_vec);
            if (o_valid) begin
               chk("ready_low_busy", o_ready, 0);
               if (i_ready) begin
                  chk("beat_expected", sb.size() != 0, 1);
                  if (sb.size() != 0) begin
                     b = sb.pop_front();
                     if (b.chkd) chk("data", o_data, b.d);
                     chk("flags {scale,elem_last,burst_last,nan}", {o_is_scale, o_elem_last, o_burst_last, o_nan},
                         {b.s, b.el, b.bl, b.n});
                  end
               end
            end
            held = o_valid && !i_ready;
            held_vec = {o_valid, o_data, o_is_scale, o_elem_last, o_burst_last, o_nan};
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      send(32'h3F800000, 8'd1);
      drain();
      @(negedge clk);
      chk("ready_after_burst", {o_ready, o_valid}, 2'b10);
      send(32'hBFC00000, 8'd3);
      drain();
      send(32'h3FFFFFFF, 8'd0);
      drain();
      send(32'h7F7FFFFF, 8'd1);
      drain();
      send(32'hFF7FFFFF, 8'd1);
      drain();
      send(32'h7FC00000, 8'd1);
      drain();
      rand_ready = 1;
      hold_valid = 1;
      for (int n = 0; n < 10; n++) send(rnd_f32(), 8'($urandom_range(0, 2)));
      hold_valid = 0;
      @(posedge clk); #1 i_valid = 0;
      drain();
      rand_ready = 0;
      send(32'h3F800000, 8'd2);
      repeat (11) @(posedge clk);
      #1 rst = 1;
      sb.delete();
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("post_reset_idle", {o_valid, o_ready}, 2'b01);
      send(32'h40000000, 8'd1);
      drain();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
